// File: rtl/nx_mesh_controller.sv
// Generic first-word-fall-through FIFO; pointers carry an extra wrap bit for full/empty.
// Latency: 1 cycle from push to out_vld.
// Backpressure: in_rdy is !full only, so a full FIFO refuses pushes even while popping.
module nx_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         push;
  logic         pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_rdy  = !full;
  assign out_vld = (wr_ptr != rd_ptr);
  assign out_dat = mem[rd_ptr[AW-1:0]];
  assign push    = in_vld && !full;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_dat;
  end
endmodule

// Host-side mesh controller: inbound/outbound message FIFOs, token regrant loop, trigger sequencer.
// Latency: 1 cycle through each FIFO; grants follow releases by 1 cycle; triggers need IDLE_SETTLE quiet cycles.
// Backpressure: host_ready_o / mesh_ready_o follow !full of their FIFO; start_i is dropped while busy.
module nx_mesh_controller #(
  parameter int COLUMNS     = 3,
  parameter int IB_DEPTH    = 4,
  parameter int OB_DEPTH    = 4,
  parameter int IDLE_SETTLE = 2,
  parameter int MSG_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MSG_W-1:0]   host_data_i,
  input  logic               host_valid_i,
  output logic               host_ready_o,
  output logic [MSG_W-1:0]   mesh_data_o,
  output logic               mesh_valid_o,
  input  logic               mesh_ready_i,
  input  logic [MSG_W-1:0]   mesh_data_i,
  input  logic               mesh_valid_i,
  output logic               mesh_ready_o,
  output logic [MSG_W-1:0]   collect_data_o,
  output logic               collect_valid_o,
  input  logic               collect_ready_i,
  input  logic               start_i,
  input  logic [15:0]        cycles_i,
  output logic               busy_o,
  output logic               mesh_trigger_o,
  input  logic               mesh_idle_i,
  output logic [COLUMNS-1:0] token_grant_o,
  input  logic [COLUMNS-1:0] token_release_i,
  output logic [31:0]        cycle_count_o
);
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_TRIG = 2'd3;
  localparam int SW = $clog2(IDLE_SETTLE + 1);

  logic [1:0]         state;
  logic [15:0]        remaining;
  logic [SW-1:0]      settle;
  logic [COLUMNS-1:0] release_q;
  logic               quiet;

  nx_fifo #(.W(MSG_W), .DEPTH(IB_DEPTH)) u_ib_fifo (
    .clk_i  (clk_i),          .rst_i  (rst_i),
    .in_dat (host_data_i),    .in_vld (host_valid_i), .in_rdy (host_ready_o),
    .out_dat(mesh_data_o),    .out_vld(mesh_valid_o), .out_rdy(mesh_ready_i)
  );

  nx_fifo #(.W(MSG_W), .DEPTH(OB_DEPTH)) u_ob_fifo (
    .clk_i  (clk_i),          .rst_i  (rst_i),
    .in_dat (mesh_data_i),    .in_vld (mesh_valid_i),    .in_rdy (mesh_ready_o),
    .out_dat(collect_data_o), .out_vld(collect_valid_o), .out_rdy(collect_ready_i)
  );

  // An FWFT FIFO is empty exactly when it is not presenting valid, so one term covers both.
  assign quiet          = mesh_idle_i && !mesh_valid_o;
  assign busy_o         = (state == ST_WAIT) || (state == ST_TRIG);
  assign mesh_trigger_o = (state == ST_TRIG);
  // INIT grants every column once; the rst_i term keeps grants low while reset is held.
  assign token_grant_o  = (state == ST_INIT && !rst_i) ? '1 : release_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_INIT;
      remaining     <= '0;
      settle        <= '0;
      release_q     <= '0;
      cycle_count_o <= '0;
    end else begin
      release_q <= token_release_i;
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (start_i && cycles_i != 16'd0) begin
            remaining <= cycles_i;
            settle    <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!quiet) begin
            settle <= '0;
          end else if (settle == SW'(IDLE_SETTLE - 1)) begin
            settle <= '0;
            state  <= ST_TRIG;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        ST_TRIG: begin
          cycle_count_o <= cycle_count_o + 32'd1;
          remaining     <= remaining - 16'd1;
          settle        <= '0;
          state         <= (remaining == 16'd1) ? ST_IDLE : ST_WAIT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nx_mesh_controller.sv
// Randomized scoreboard bench for nx_mesh_controller; a negedge monitor compares every output
// against queue models of the FIFOs and a cycle-arithmetic model of the trigger rules.
module tb_nx_mesh_controller;
  localparam int COLUMNS     = 3;
  localparam int IB_DEPTH    = 4;
  localparam int OB_DEPTH    = 4;
  localparam int IDLE_SETTLE = 2;
  localparam int MSG_W       = 32;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [MSG_W-1:0]   host_data_i;
  logic               host_valid_i;
  logic               host_ready_o;
  logic [MSG_W-1:0]   mesh_data_o;
  logic               mesh_valid_o;
  logic               mesh_ready_i;
  logic [MSG_W-1:0]   mesh_data_i;
  logic               mesh_valid_i;
  logic               mesh_ready_o;
  logic [MSG_W-1:0]   collect_data_o;
  logic               collect_valid_o;
  logic               collect_ready_i;
  logic               start_i;
  logic [15:0]        cycles_i;
  logic               busy_o;
  logic               mesh_trigger_o;
  logic               mesh_idle_i;
  logic [COLUMNS-1:0] token_grant_o;
  logic [COLUMNS-1:0] token_release_i;
  logic [31:0]        cycle_count_o;

  nx_mesh_controller #(
    .COLUMNS(COLUMNS), .IB_DEPTH(IB_DEPTH), .OB_DEPTH(OB_DEPTH),
    .IDLE_SETTLE(IDLE_SETTLE), .MSG_W(MSG_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_data_i(host_data_i), .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
    .mesh_data_o(mesh_data_o), .mesh_valid_o(mesh_valid_o), .mesh_ready_i(mesh_ready_i),
    .mesh_data_i(mesh_data_i), .mesh_valid_i(mesh_valid_i), .mesh_ready_o(mesh_ready_o),
    .collect_data_o(collect_data_o), .collect_valid_o(collect_valid_o),
    .collect_ready_i(collect_ready_i),
    .start_i(start_i), .cycles_i(cycles_i), .busy_o(busy_o),
    .mesh_trigger_o(mesh_trigger_o), .mesh_idle_i(mesh_idle_i),
    .token_grant_o(token_grant_o), .token_release_i(token_release_i),
    .cycle_count_o(cycle_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  logic [MSG_W-1:0]   ib_q[$];
  logic [MSG_W-1:0]   ob_q[$];
  logic [COLUMNS-1:0] prev_rel;
  logic [31:0]        count_m;
  int                 rem_m;
  bit                 busy_m;
  bit                 init_m;
  int                 cyc     = 0;
  int                 last_ev = -100;
  int                 last_nq = -100;

  always @(negedge clk_i) begin
    bit ib_full, ib_empty, ob_full, ob_empty, exp_trig, was_busy;
    int base;
    cyc++;
    if (rst_i) begin
      chk("rst_host_ready", host_ready_o, 1);
      chk("rst_mesh_ready", mesh_ready_o, 1);
      chk("rst_mesh_valid", mesh_valid_o, 0);
      chk("rst_collect_valid", collect_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_trigger", mesh_trigger_o, 0);
      chk("rst_grant", token_grant_o, 0);
      chk("rst_count", cycle_count_o, 0);
      ib_q.delete();
      ob_q.delete();
      prev_rel = '0;
      count_m  = '0;
      rem_m    = 0;
      busy_m   = 0;
      init_m   = 1;
      last_ev  = -100;
      last_nq  = -100;
    end else begin
      chk("token_grant", token_grant_o, init_m ? {COLUMNS{1'b1}} : prev_rel);
      prev_rel = token_release_i;

      ib_full  = (ib_q.size() >= IB_DEPTH);
      ib_empty = (ib_q.size() == 0);
      chk("host_ready", host_ready_o, !ib_full);
      chk("mesh_valid", mesh_valid_o, !ib_empty);
      if (!ib_empty && mesh_valid_o) chk("mesh_data", mesh_data_o, ib_q[0]);
      if (!ib_empty && mesh_ready_i) void'(ib_q.pop_front());
      if (host_valid_i && !ib_full) ib_q.push_back(host_data_i);

      ob_full  = (ob_q.size() >= OB_DEPTH);
      ob_empty = (ob_q.size() == 0);
      chk("mesh_ready", mesh_ready_o, !ob_full);
      chk("collect_valid", collect_valid_o, !ob_empty);
      if (!ob_empty && collect_valid_o) chk("collect_data", collect_data_o, ob_q[0]);
      if (!ob_empty && collect_ready_i) void'(ob_q.pop_front());
      if (mesh_valid_i && !ob_full) ob_q.push_back(mesh_data_i);

      // A trigger fires once IDLE_SETTLE quiet cycles have elapsed since the start or the last trigger.
      base     = (last_ev > last_nq) ? last_ev : last_nq;
      exp_trig = busy_m && ((cyc - base - 1) >= IDLE_SETTLE);
      chk("busy", busy_o, busy_m);
      chk("trigger", mesh_trigger_o, exp_trig);
      chk("cycle_count", cycle_count_o, count_m);
      if (!(mesh_idle_i && ib_empty)) last_nq = cyc;
      was_busy = busy_m;
      if (exp_trig) begin
        count_m = count_m + 32'd1;
        rem_m--;
        last_ev = cyc;
        if (rem_m == 0) busy_m = 0;
      end
      if (!was_busy && !init_m && start_i && cycles_i != 16'd0) begin
        busy_m  = 1;
        rem_m   = cycles_i;
        last_ev = cyc;
      end
      init_m = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    host_valid_i = 0; mesh_valid_i = 0; mesh_ready_i = 1; collect_ready_i = 1;
    start_i = 0; cycles_i = '0; token_release_i = '0;
  endtask

  task automatic random_phase(input int n, input bit with_starts);
    for (int i = 0; i < n; i++) begin
      host_valid_i    = ($urandom_range(0, 2) != 0);
      host_data_i     = $urandom;
      mesh_ready_i    = ($urandom_range(0, 2) != 0);
      mesh_valid_i    = ($urandom_range(0, 2) != 0);
      mesh_data_i     = $urandom;
      collect_ready_i = ($urandom_range(0, 2) != 0);
      mesh_idle_i     = ($urandom_range(0, 3) != 0);
      token_release_i = ($urandom_range(0, 3) == 0) ? COLUMNS'($urandom) : '0;
      start_i         = with_starts && ($urandom_range(0, 7) == 0);
      cycles_i        = 16'($urandom_range(0, 3));
      tick(1);
    end
    quiet_inputs();
    mesh_idle_i = 1;
    tick(40);
  endtask

  initial begin
    rst_i = 1; mesh_idle_i = 0; host_data_i = '0; mesh_data_i = '0;
    quiet_inputs();
    tick(3);
    rst_i = 0;
    tick(3);

    // Fill inbound FIFO with the mesh stalled; the fifth push must be refused.
    mesh_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      host_valid_i = 1; host_data_i = $urandom; tick(1);
    end
    host_valid_i = 0; tick(1);
    mesh_ready_i = 1; tick(6);

    // Fill outbound FIFO with the host stalled, then hold the fifth until it is taken.
    collect_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      mesh_valid_i = 1; mesh_data_i = $urandom; tick(1);
    end
    mesh_data_i = $urandom; tick(2);
    collect_ready_i = 1; tick(2);
    mesh_valid_i = 0; tick(6);

    random_phase(200, 0);

    // Three triggers with the mesh idle throughout.
    mesh_idle_i = 1;
    start_i = 1; cycles_i = 16'd3; tick(1);
    start_i = 0; tick(14);

    // Mesh busy for 10 cycles; a second start while busy is dropped.
    mesh_idle_i = 0;
    start_i = 1; cycles_i = 16'd2; tick(1);
    start_i = 0; tick(4);
    start_i = 1; cycles_i = 16'd5; tick(1);
    start_i = 0; tick(4);
    mesh_idle_i = 1; tick(12);

    // Zero-length request is ignored.
    start_i = 1; cycles_i = 16'd0; tick(1);
    start_i = 0; tick(3);

    token_release_i = 3'b101; tick(1);
    token_release_i = '0; tick(3);

    // Reset in the middle of a WAIT with messages queued.
    mesh_idle_i = 0; mesh_ready_i = 0;
    start_i = 1; cycles_i = 16'd4; host_valid_i = 1; host_data_i = $urandom; tick(1);
    start_i = 0; host_data_i = $urandom; tick(1);
    host_valid_i = 0; tick(2);
    rst_i = 1; tick(1);
    rst_i = 0; mesh_ready_i = 1; tick(4);

    random_phase(300, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
